// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with a 2-bit saturating
// direction counter per entry, trained from EX, plus a saturating mispredict counter.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] PC,
  output logic        Pre_Branch,
  output logic [31:0] Pre_PC,
  input  logic        Upd_Valid,
  input  logic [31:0] Upd_PC,
  input  logic        Upd_Taken,
  input  logic [31:0] Upd_Target,
  input  logic        Upd_Pred_Taken,
  output logic [31:0] Miss_Cnt
);

  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]   lk_idx, up_idx;
  logic [TAG_W-1:0]   lk_tag, up_tag;
  logic               lk_hit, up_hit;
  logic               wr_entry;
  logic               unused_lsbs;

  assign unused_lsbs = ^{PC[1:0], Upd_PC[1:0]};

  // Lookup: purely combinational, sees the state before any same-cycle update.
  assign lk_idx     = PC[IDX_W+1:2];
  assign lk_tag     = PC[31:IDX_W+2];
  assign lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign Pre_Branch = lk_hit && ctr_q[lk_idx][1];
  assign Pre_PC     = Pre_Branch ? target_q[lk_idx] : (PC + 32'd4);

  assign up_idx = Upd_PC[IDX_W+1:2];
  assign up_tag = Upd_PC[31:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    valid_d = valid_q;
    ctr_d   = ctr_q;
    if (Upd_Valid) begin
      if (up_hit) begin
        if (Upd_Taken) begin
          if (ctr_q[up_idx] != 2'b11) ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
        end else begin
          if (ctr_q[up_idx] != 2'b00) ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
        end
      end else if (Upd_Taken) begin
        valid_d[up_idx] = 1'b1;
        ctr_d[up_idx]   = 2'b10;
      end
    end
  end

  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (Upd_Valid && (Upd_Pred_Taken != Upd_Taken) && (miss_cnt_q != 32'hFFFF_FFFF))
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  // Both a taken hit and an allocation rewrite tag+target; on a hit the tag is unchanged.
  // Qualified with rstn so an edge seen during reset writes nothing.
  assign wr_entry = rstn && Upd_Valid && Upd_Taken;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q    <= '0;
      miss_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else begin
      valid_q    <= valid_d;
      miss_cnt_q <= miss_cnt_d;
      ctr_q      <= ctr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_entry) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= Upd_Target;
    end
  end

  assign Miss_Cnt = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, async-reset and
// counter-saturation sequences, then random traffic against an array model.
module tb_branch_predictor;

  localparam int ENT = 16;

  logic        clk, rstn;
  logic [31:0] PC, Pre_PC, Upd_PC, Upd_Target, Miss_Cnt;
  logic        Pre_Branch, Upd_Valid, Upd_Taken, Upd_Pred_Taken;

  int n_checks = 0;
  int n_errors = 0;

  branch_predictor #(.ENTRIES(ENT)) dut (
    .clk(clk), .rstn(rstn), .PC(PC), .Pre_Branch(Pre_Branch), .Pre_PC(Pre_PC),
    .Upd_Valid(Upd_Valid), .Upd_PC(Upd_PC), .Upd_Taken(Upd_Taken),
    .Upd_Target(Upd_Target), .Upd_Pred_Taken(Upd_Pred_Taken), .Miss_Cnt(Miss_Cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit          m_valid  [ENT];
  longint      m_tag    [ENT];
  logic [31:0] m_target [ENT];
  int          m_ctr    [ENT];
  longint      m_miss;

  function automatic void m_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 1;
    end
    m_miss = 0;
  endfunction

  function automatic bit m_pred(input logic [31:0] pc, output logic [31:0] npc);
    int     idx = int'((pc / 4) % ENT);
    longint tag = longint'(pc / (4 * ENT));
    bit     br  = m_valid[idx] && (m_tag[idx] == tag) && (m_ctr[idx] >= 2);
    npc = br ? m_target[idx] : pc + 32'd4;
    return br;
  endfunction

  function automatic void m_update(input logic [31:0] upc, input bit t,
                                   input logic [31:0] tgt, input bit pt);
    int     idx = int'((upc / 4) % ENT);
    longint tag = longint'(upc / (4 * ENT));
    if (m_valid[idx] && m_tag[idx] == tag) begin
      if (t) begin
        m_ctr[idx]    = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
        m_target[idx] = tgt;
      end else begin
        m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
      end
    end else if (t) begin
      m_valid[idx]  = 1;
      m_tag[idx]    = tag;
      m_target[idx] = tgt;
      m_ctr[idx]    = 2;
    end
    if (pt != t && m_miss < 64'h0_FFFF_FFFF) m_miss++;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        upt;
    logic [31:0] pc;
    logic        ebr;
    logic [31:0] epc;
    logic [31:0] emiss;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic uv, input logic [31:0] upc, input logic ut,
                              input logic [31:0] utgt, input logic upt, input logic [31:0] pc,
                              input logic ebr, input logic [31:0] epc, input logic [31:0] emiss);
    vec_t v;
    v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.upt = upt;
    v.pc = pc; v.ebr = ebr; v.epc = epc; v.emiss = emiss;
    return v;
  endfunction

  localparam logic [31:0] A10 = 32'h1C00_0010, A50 = 32'h1C00_0050, A90 = 32'h1C00_0090;
  localparam logic [31:0] A20 = 32'h1C00_0020, T100 = 32'h1C00_0100;

  task automatic idle_inputs();
    Upd_Valid = 0; Upd_PC = 0; Upd_Taken = 0; Upd_Target = 0; Upd_Pred_Taken = 0;
  endtask

  initial begin
    logic [31:0] npc;
    bit          br;

    // Expected outputs are for the lookup in the same cycle, i.e. before that row's update.
    vecs.push_back(mk(1, A10, 1, T100, 0, A10, 0, A10 + 4, 0));   // allocate, miss 1
    vecs.push_back(mk(0, 0,   0, 0,    0, A10, 1, T100,    1));
    vecs.push_back(mk(0, 0,   0, 0,    0, A50, 0, A50 + 4, 1));   // same index, other tag
    vecs.push_back(mk(1, A10, 1, T100, 1, A10, 1, T100,    1));   // ctr 3
    vecs.push_back(mk(1, A10, 1, T100, 1, A10, 1, T100,    1));
    vecs.push_back(mk(1, A10, 1, T100, 1, A10, 1, T100,    1));
    vecs.push_back(mk(1, A10, 0, 0,    1, A10, 1, T100,    1));   // ctr 2, miss 2
    vecs.push_back(mk(0, 0,   0, 0,    0, A10, 1, T100,    2));
    vecs.push_back(mk(1, A10, 0, 0,    1, A10, 1, T100,    2));   // ctr 1, miss 3
    vecs.push_back(mk(0, 0,   0, 0,    0, A10, 0, A10 + 4, 3));
    vecs.push_back(mk(1, A10, 0, 0,    0, A10, 0, A10 + 4, 3));   // ctr 0
    vecs.push_back(mk(1, A10, 0, 0,    0, A10, 0, A10 + 4, 3));   // stays 0
    vecs.push_back(mk(1, A10, 1, T100, 0, A10, 0, A10 + 4, 3));   // ctr 1, miss 4
    vecs.push_back(mk(0, 0,   0, 0,    0, A10, 0, A10 + 4, 4));
    vecs.push_back(mk(1, A10, 1, T100, 0, A10, 0, A10 + 4, 4));   // ctr 2, miss 5
    vecs.push_back(mk(0, 0,   0, 0,    0, A10, 1, T100,    5));
    vecs.push_back(mk(1, A50, 1, 32'h2000, 0, A10, 1, T100, 5));  // conflict, miss 6
    vecs.push_back(mk(0, 0,   0, 0,    0, A10, 0, A10 + 4, 6));
    vecs.push_back(mk(0, 0,   0, 0,    0, A50, 1, 32'h2000, 6));
    vecs.push_back(mk(1, A90, 0, 0,    0, A50, 1, 32'h2000, 6));  // not-taken miss: no alloc
    vecs.push_back(mk(0, 0,   0, 0,    0, A50, 1, 32'h2000, 6));
    vecs.push_back(mk(0, 0,   0, 0,    0, A90, 0, A90 + 4, 6));
    vecs.push_back(mk(1, A20, 1, 32'h1C00_0200, 0, A20, 0, A20 + 4, 6)); // no bypass, miss 7
    vecs.push_back(mk(0, 0,   0, 0,    0, A20, 1, 32'h1C00_0200, 7));

    rstn = 0; PC = 32'h1C00_0000;
    idle_inputs();
    #1;
    chk("reset_async_branch", {31'd0, Pre_Branch}, 32'd0);
    chk("reset_async_pc", Pre_PC, 32'h1C00_0004);
    repeat (2) @(negedge clk);
    rstn = 1;

    for (int a = 0; a <= 32'h3C; a += 4) begin
      @(negedge clk);
      PC = 32'h1C00_0000 + a;
      #1;
      chk("sweep_branch", {31'd0, Pre_Branch}, 32'd0);
      chk("sweep_pc", Pre_PC, PC + 32'd4);
    end
    chk("sweep_miss", Miss_Cnt, 32'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      Upd_Valid = vecs[i].uv; Upd_PC = vecs[i].upc; Upd_Taken = vecs[i].ut;
      Upd_Target = vecs[i].utgt; Upd_Pred_Taken = vecs[i].upt; PC = vecs[i].pc;
      #1;
      chk($sformatf("vec%0d_branch", i), {31'd0, Pre_Branch}, {31'd0, vecs[i].ebr});
      chk($sformatf("vec%0d_pc", i), Pre_PC, vecs[i].epc);
      chk($sformatf("vec%0d_miss", i), Miss_Cnt, vecs[i].emiss);
    end

    // Async reset between edges with an allocation pending.
    @(negedge clk);
    Upd_Valid = 1; Upd_PC = 32'h1C00_0030; Upd_Taken = 1; Upd_Target = 32'h300;
    Upd_Pred_Taken = 0; PC = A20;
    #1;
    chk("prerst_branch", {31'd0, Pre_Branch}, 32'd1);
    #1;
    rstn = 0;
    #1;
    chk("midrst_branch", {31'd0, Pre_Branch}, 32'd0);
    chk("midrst_pc", Pre_PC, A20 + 4);
    chk("midrst_miss", Miss_Cnt, 32'd0);
    @(negedge clk);
    idle_inputs();
    rstn = 1;
    PC = 32'h1C00_0030;
    #1;
    chk("postrst_alloc_branch", {31'd0, Pre_Branch}, 32'd0);
    chk("postrst_alloc_pc", Pre_PC, 32'h1C00_0034);
    PC = A50;
    #1;
    chk("postrst_old_branch", {31'd0, Pre_Branch}, 32'd0);
    chk("postrst_miss", Miss_Cnt, 32'd0);

    // Random traffic against the model.
    m_reset();
    for (int c = 0; c < 500; c++) begin
      logic [31:0] upc;
      logic        ut, upt;
      logic [31:0] utgt;
      @(negedge clk);
      PC   = 32'h1C00_0000 + ($urandom_range(0, 47) << 2);
      upc  = ($urandom_range(0, 3) == 0) ? PC : 32'h1C00_0000 + ($urandom_range(0, 47) << 2);
      ut   = 1'($urandom_range(0, 1));
      utgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 1) == 0) upt = m_pred(upc, npc);
      else                           upt = 1'($urandom_range(0, 1));
      Upd_Valid = ($urandom_range(0, 9) < 7);
      Upd_PC = upc; Upd_Taken = ut; Upd_Target = utgt; Upd_Pred_Taken = upt;
      #1;
      br = m_pred(PC, npc);
      chk("rnd_branch", {31'd0, Pre_Branch}, {31'd0, br});
      chk("rnd_pc", Pre_PC, npc);
      chk("rnd_miss", Miss_Cnt, m_miss[31:0]);
      if (Upd_Valid) m_update(upc, ut, utgt, upt);
    end

    // Miss counter saturation.
    @(negedge clk);
    idle_inputs();
    force dut.miss_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.miss_cnt_q;
    #1;
    chk("sat_preload", Miss_Cnt, 32'hFFFF_FFFE);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      Upd_Valid = 1; Upd_PC = 32'h1C00_0008; Upd_Taken = 1;
      Upd_Target = 32'h1C00_0800; Upd_Pred_Taken = 0;
      @(negedge clk);
      idle_inputs();
      #1;
      chk($sformatf("sat_miss%0d", k), Miss_Cnt, 32'hFFFF_FFFF);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage branch predictor: a direct-mapped branch target buffer (BTB) with one 2-bit saturating counter per entry. Every cycle it looks up the current fetch PC combinationally and drives `Pre_Branch`/`Pre_PC` straight into the next-PC select logic. The execute stage trains it with resolved branch outcomes. It also keeps a saturating mispredict counter for performance monitoring.

## Interface
- `ENTRIES`, default 16: number of BTB entries; power of two, 4..256.
- `IDX_W`, default log2(`ENTRIES`) = 4: index width.
- `clk`  in  1  rising-edge clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `PC`  in  `WORD` (32)  current fetch PC, word aligned.
- `Pre_Branch`  out  1  predicted taken for `PC`.
- `Pre_PC`  out  32  predicted target when `Pre_Branch`=1, otherwise `PC`+4.
- `Upd_Valid`  in  1  a branch/jump resolved in EX this cycle.
- `Upd_PC`  in  32  PC of the resolved branch.
- `Upd_Taken`  in  1  actual direction.
- `Upd_Target`  in  32  actual taken target.
- `Upd_Pred_Taken`  in  1  the `Pre_Branch` value this branch received at fetch, carried down the pipeline.
- `Miss_Cnt`  out  32  count of direction mispredicts; saturates.

## Operation
- Address split:
  - index = `PC`[IDX_W+1:2]
  - tag = `PC`[31:IDX_W+2]
  - `Upd_PC` uses the same split.
- Per-entry state: valid (1 bit), tag, target (32 bits), ctr (2 bits).
- Lookup (combinational): hit = valid & tag match.
  - `Pre_Branch` = hit & ctr[1].
  - `Pre_PC` = target when `Pre_Branch` = 1, otherwise `PC`+4 (mod 2^32, wraps).
- Update, applied on the clock edge when `Upd_Valid`=1:
  - Hit and taken: ctr = min(ctr+1, 3); target = `Upd_Target`.
  - Hit and not taken: ctr = max(ctr−1, 0); target unchanged.
  - Miss and taken: allocate. valid=1, tag and target written, ctr=2'b10, overwriting any entry with a different tag.
  - Miss and not taken: no state change.
- `Miss_Cnt` increments when `Upd_Valid` & (`Upd_Pred_Taken` != `Upd_Taken`). It holds at 32'hFFFF_FFFF.
- Target mispredicts are not counted; the EX redirect corrects them.
- `Upd_Valid`=0: no state change; `Upd_*` are don't-care.
- Reset (`rstn`=0, async):
  - All valid=0, all ctr=2'b01, `Miss_Cnt`=0.
  - Tags and targets need no reset.
  - Outputs immediately read `Pre_Branch`=0, `Pre_PC`=`PC`+4.
- Reset asserted in the middle of an update aborts that update entirely.
- No flush or stall inputs. An update during a fetch stall is still applied.

## Timing
- Lookup latency: 0 cycles, purely combinational from `PC` and state. There are no registers on the `PC` → `Pre_*` path.
- Update latency: 1 cycle. An update sampled at edge N is visible to lookups from just after edge N.
- Same cycle, same index: the lookup sees the pre-update state. There is no write-to-read bypass.
- One update per cycle maximum.
- `Miss_Cnt` is registered and changes only on the clock edge or on reset.
- Critical path: index decode → tag compare → target mux. Keep `ENTRIES` ≤ 64 when the storage is flops.

## Test plan
- Reset, then sweep `PC`=0x1C00_0000..0x1C00_003C: `Pre_Branch`=0 and `Pre_PC`=`PC`+4 for every value; `Miss_Cnt`=0.
- Allocation:
  - Stimulus: update `Upd_PC`=0x1C00_0010, taken, `Upd_Target`=0x1C00_0100, `Upd_Pred_Taken`=0.
  - Next cycle, `PC`=0x1C00_0010 → `Pre_Branch`=1, `Pre_PC`=0x1C00_0100, `Miss_Cnt`=1.
  - `PC`=0x1C00_0050 (same index, different tag) → `Pre_Branch`=0.
- Counter saturation and hysteresis on that entry:
  - 3 taken updates → ctr=3.
  - 1 not-taken → still predicts taken.
  - 2nd not-taken → `Pre_Branch`=0.
  - 2 more not-taken → ctr=0; 1 taken → still 0; 2nd taken → predicts taken.
- Conflict and no-allocate:
  - Taken update at 0x1C00_0050, target 0x2000 → 0x1C00_0010 now misses and 0x1C00_0050 predicts 0x2000.
  - Not-taken update at 0x1C00_0090 (miss) → the entry is unchanged.
- Same-cycle read/write: `PC`=0x1C00_0020 while allocating 0x1C00_0020 → `Pre_Branch`=0 that cycle and 1 the next cycle.
- Async reset mid-update: drop `rstn` between edges while an update is pending → outputs go to `PC`+4 without waiting for `clk`; `Miss_Cnt`=0; after release the entry is invalid.
- `Miss_Cnt` saturation: preload it to 32'hFFFF_FFFE via hierarchical force, then apply 3 mispredicting updates → the count reads 32'hFFFF_FFFF.
